pow_n_multi_cycle: RTL and testbench

POW_N_MULTI_CYCLE -- requirements
Module: pow_n_multi_cycle

---
 rtl/pow_n_pkg.sv | 13 +
 rtl/pow_n_mul.sv | 19 +
 rtl/pow_n_multi_cycle.sv | 120 ++++++++++++
 tb/tb_pow_n_multi_cycle.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pow_n_pkg.sv
// Shared types and default widths for the multi-cycle power unit.
package pow_n_pkg;

    localparam int W_DEF  = 8;
    localparam int EW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/pow_n_mul.sv
// Purpose: combinational w x w multiply, truncated product plus upper-half-nonzero flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module pow_n_mul #(
    parameter int w = 8
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic [w-1:0] prod,
    output logic         hi_nz
);

    logic [2*w-1:0] full;

    assign full  = {{w{1'b0}}, a} * {{w{1'b0}}, b};
    assign prod  = full[w-1:0];
    assign hi_nz = |full[2*w-1:w];

endmodule

// File: rtl/pow_n_multi_cycle.sv
// Purpose: n**e mod 2**w by repeated multiply; res_ovf port exists only under POW_N_OVF_EN.
// Latency: e+1 enabled edges from accept to res_vld; one multiply step per enabled edge.
// Backpressure: result held in DONE until res_rdy; n_rdy only in IDLE, no accept on the take edge.
module pow_n_multi_cycle
    import pow_n_pkg::*;
#(
    parameter int w  = W_DEF,
    parameter int ew = EW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          n_vld,
    output logic          n_rdy,
    input  logic [w-1:0]  n,
    input  logic [ew-1:0] e,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [w-1:0]  res
`ifdef POW_N_OVF_EN
    ,
    output logic          res_ovf
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic [w-1:0]  acc;
    logic [ew-1:0] cnt;
    logic [w-1:0]  n_latched;
    logic          accept;
    logic          step;
    logic [w-1:0]  prod;
    logic          hi_nz;

    pow_n_mul #(.w(w)) u_mul (
        .a     (acc),
        .b     (n_latched),
        .prod  (prod),
        .hi_nz (hi_nz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clk_en gates every transition, so handshakes are invisible while it is low.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        n_rdy     = (state == IDLE);
        res_vld   = (state == DONE);
        if (clk_en) begin
            case (state)
                IDLE: begin
                    if (n_vld) begin
                        accept    = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        step = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (res_rdy) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= w'(1);
            cnt       <= '0;
            n_latched <= '0;
        end else if (accept) begin
            acc       <= w'(1);
            cnt       <= e;
            n_latched <= n;
        end else if (step) begin
            acc <= prod;
            cnt <= cnt - ew'(1);
        end
    end

    assign res = acc;

`ifdef POW_N_OVF_EN
    logic ovf;

    // Sticky across the whole operation; any step that lost upper bits marks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= 1'b0;
        end else if (step && hi_nz) begin
            ovf <= 1'b1;
        end
    end

    assign res_ovf = ovf;
`else
    logic unused_hi_nz;
    assign unused_hi_nz = hi_nz;
`endif

endmodule

// File: tb/tb_pow_n_multi_cycle.sv
// Directed-vector bench for pow_n_multi_cycle with hand-computed powers and latencies.
module tb_pow_n_multi_cycle;

    localparam int W  = 8;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic          n_vld;
    logic          n_rdy;
    logic [W-1:0]  n;
    logic [EW-1:0] e;
    logic          res_vld;
    logic          res_rdy;
    logic [W-1:0]  res;
`ifdef POW_N_OVF_EN
    logic          res_ovf;
`endif

    int  errors = 0;
    int  checks = 0;
    bit  toggle_en = 1'b0;
    int  last_edges;

    always #5 clk = ~clk;

    pow_n_multi_cycle #(.w(W), .ew(EW)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .n_vld   (n_vld),
        .n_rdy   (n_rdy),
        .n       (n),
        .e       (e),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res     (res)
`ifdef POW_N_OVF_EN
        ,
        .res_ovf (res_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input string tag, input logic [W-1:0] nv, input logic [EW-1:0] ev);
        int guard;
        guard  = 0;
        clk_en = 1'b1;
        while (!n_rdy && guard < 50) begin
            tick;
            guard++;
        end
        check({tag, "_rdy"}, n_rdy, 1);
        n     = nv;
        e     = ev;
        n_vld = 1'b1;
        tick;
        n_vld = 1'b0;
        // Scramble operands while busy; the result must not change.
        n     = '1;
        e     = '1;
        check({tag, "_busy"}, n_rdy, 0);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int exp_res, input int exp_ovf);
        int en_edges;
        int edges;
        en_edges = 0;
        edges    = 0;
        while (!res_vld && edges < 200) begin
            if (clk_en) en_edges++;
            tick;
            edges++;
            if (toggle_en) clk_en = ~clk_en;
        end
        last_edges = edges;
        check({tag, "_vld"}, res_vld, 1);
        check({tag, "_lat"}, en_edges, exp_lat);
        check({tag, "_res"}, res, exp_res);
`ifdef POW_N_OVF_EN
        check({tag, "_ovf"}, res_ovf, exp_ovf);
`else
        if (exp_ovf > 1) check({tag, "_ovf_arg"}, exp_ovf, 0);
`endif
    endtask

    task automatic take(input string tag);
        clk_en  = 1'b1;
        res_rdy = 1'b1;
        tick;
        res_rdy = 1'b0;
        check({tag, "_idle"}, n_rdy, 1);
        check({tag, "_vld_drop"}, res_vld, 0);
    endtask

    initial begin
        bit stable;
        bit saw_vld;
        logic [W-1:0] held;

        rst     = 1'b1;
        clk_en  = 1'b0;
        n_vld   = 1'b0;
        res_rdy = 1'b0;
        n       = '0;
        e       = '0;
        tick;
        tick;
        check("rst_n_rdy", n_rdy, 1);
        check("rst_res_vld", res_vld, 0);
        check("rst_res", res, 1);
`ifdef POW_N_OVF_EN
        check("rst_ovf", res_ovf, 0);
`endif
        rst    = 1'b0;
        clk_en = 1'b1;
        tick;
        check("idle_hold", n_rdy, 1);

        // 3**5 = 243, no overflow
        start_op("p3_5", 8'd3, 4'd5);
        wait_done("p3_5", 6, 243, 0);
        take("p3_5");

        start_op("p7_0", 8'd7, 4'd0);
        wait_done("p7_0", 1, 1, 0);
        take("p7_0");
        start_op("p0_3", 8'd0, 4'd3);
        wait_done("p0_3", 4, 0, 0);
        take("p0_3");
        start_op("p0_0", 8'd0, 4'd0);
        wait_done("p0_0", 1, 1, 0);
        take("p0_0");

        // 4**4 = 256 wraps to 0 with overflow; next op must clear the flag
        start_op("p4_4", 8'd4, 4'd4);
        wait_done("p4_4", 5, 0, 1);
        take("p4_4");
        start_op("p2_3", 8'd2, 4'd3);
        wait_done("p2_3", 4, 8, 0);
        take("p2_3");
        // 255**2 = 65025 -> 1 mod 256; 2**15 = 32768 -> 0 mod 256
        start_op("p255_2", 8'd255, 4'd2);
        wait_done("p255_2", 3, 1, 1);
        take("p255_2");
        start_op("p2_15", 8'd2, 4'd15);
        wait_done("p2_15", 16, 0, 1);
        take("p2_15");

        // Hold in DONE with res_rdy low, then res_rdy ignored while clk_en low
        start_op("hold", 8'd2, 4'd5);
        wait_done("hold", 6, 32, 0);
        held   = res;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (res !== held || res_vld !== 1'b1 || n_rdy !== 1'b0) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        clk_en  = 1'b0;
        res_rdy = 1'b1;
        tick;
        check("hold_en_off", res_vld, 1);
        // Take edge with a new operand waiting: no same-edge accept
        clk_en = 1'b1;
        n_vld  = 1'b1;
        n      = 8'd9;
        e      = 4'd1;
        tick;
        res_rdy = 1'b0;
        check("nobypass_idle", n_rdy, 1);
        check("nobypass_vld", res_vld, 0);
        tick;
        n_vld = 1'b0;
        check("nobypass_accept", n_rdy, 0);
        wait_done("p9_1", 2, 9, 0);
        take("p9_1");

        // clk_en alternating: same result, latency in enabled edges only
        toggle_en = 1'b1;
        start_op("tog", 8'd3, 4'd5);
        wait_done("tog", 6, 243, 0);
        check("tog_edges", last_edges, 11);
        toggle_en = 1'b0;
        take("tog");

        // Reset mid-operation aborts without a result
        start_op("abort", 8'd5, 4'd6);
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_idle", n_rdy, 1);
        check("abort_vld", res_vld, 0);
        check("abort_res", res, 1);
`ifdef POW_N_OVF_EN
        check("abort_ovf", res_ovf, 0);
`endif
        saw_vld = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (res_vld) saw_vld = 1'b1;
        end
        check("abort_no_vld", saw_vld, 0);
        start_op("p2_2", 8'd2, 4'd2);
        wait_done("p2_2", 3, 4, 0);
        take("p2_2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
